vga_ctrl_param: RTL and testbench
=================================

# vga_ctrl_param

Parametrised VGA timing and pixel generator: the next generation of our fixed 640x480 VGA top-level. It derives pixel timing from parameters, supports a clock-enable pixel divider and selectable colour depth and sync polarity, and adds built-in test-pattern modes alongside the external framebuffer path. It drives the VGA DAC pins directly and presents pixel coordinates to a combinational-read framebuffer (vga_mem-style) in the same clock domain.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 1, i_clk cycles per pixel (>=1)
- COLOR_W, 8, bits per colour channel
- SYNC_POL, 0, sync active level (0 = active-low)
- CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels
- ADDR_W, 10, width of coordinate outputs
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mode  in  2  00 framebuffer, 01 colour bars, 10 checkerboard, 11 solid (i_vga_data)
- i_vga_data  in  3*COLOR_W  pixel {R,G,B} for current o_h_addr/o_v_addr
- o_h_addr  out  ADDR_W  active column (0 outside active region)
- o_v_addr  out  ADDR_W  active row (0 outside active region)
- o_pix_en  out  1  pixel strobe
- o_hsync, o_vsync  out  1  sync, level per SYNC_POL
- o_valid  out  1  blank_n, high in active region
- o_vga_r, o_vga_g, o_vga_b  out  COLOR_W  colour
- o_frame_start  out  1  one-pixel pulse at first active pixel output of a frame
- o_frame_cnt  out  16  completed-frame count, wraps at 65535->0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider counts 0..CLK_DIV-1; o_pix_en high when div == CLK_DIV-1 (CLK_DIV=1: high every cycle after reset).
- On o_pix_en: h_cnt increments, wraps H_TOTAL-1 -> 0; on wrap v_cnt increments, wraps V_TOTAL-1 -> 0.
- Active: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. o_h_addr/o_v_addr = h_cnt/v_cnt when active, else 0; combinational from counters.
- hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync same rule on v_cnt.
- Mode register latched from i_mode only at h_cnt==0 && v_cnt==0 (with pix_en); mid-frame changes take effect next frame. Reset value 00.
- Colour bars: 8 bars, width H_ACTIVE/8 (integer), order white, yellow, cyan, green, magenta, red, blue, black; bar index held by sequential bar counter cleared at h_cnt==0; remainder pixels stay black. Full intensity = all-ones COLOR_W.
- Checkerboard: white if bit CHK_LOG2 of (h_addr XOR v_addr) is 0, else black.
- Modes 00 and 11 pass i_vga_data.
- Inactive pixels output RGB = 0.
- o_frame_cnt increments when v_cnt wraps to 0.

## Timing
- Output stage (sync, valid, RGB, frame_start) registered on o_pix_en: outputs lag counters/addresses by exactly one pixel; framebuffer must return data combinationally in the same cycle.
- Reset (async assert, counters/outputs clear immediately): h_cnt=v_cnt=div=0, o_pix_en=0, o_hsync=o_vsync=~SYNC_POL, o_valid=0, RGB=0, o_frame_start=0, o_frame_cnt=0, mode=00.
- Reset mid-frame: restart at pixel (0,0); first pix_en CLK_DIV cycles after release.
- Between pix_en strobes all outputs hold.

## Test plan
- Small params (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1): hsync low exactly for h_cnt 10..11 (2 pixels every 14), vsync low for lines 5, frame period 98 cycles, o_valid high 32 pixels/frame.
- CLK_DIV=3: o_pix_en 1-of-3 cycles; outputs change only the cycle after strobe; frame period 294 cycles.
- Mode 01, H_ACTIVE=16: pixels 0-1 white (all ones), 2-3 yellow (R=G=FF,B=0), ..., 14-15 black; blanking RGB=0.
- Mode 10, CHK_LOG2=1: pixel (0,0) white, (2,0) black, (2,2) white.
- Change i_mode 00->11 mid-frame: output unchanged until first pixel of next frame, then i_vga_data; o_frame_start pulses once, o_frame_cnt increments by 1.
- Assert i_rst_n low mid-line: outputs to reset values same cycle (async); after release addresses restart at (0,0); o_frame_cnt=0.

Source files
------------

// File: rtl/vga_ctrl_param.sv
// Parametrised VGA timing generator with pixel-rate clock enable, test patterns
// and a one-pixel registered output stage feeding the DAC pins.
module vga_ctrl_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 1,
  parameter int COLOR_W  = 8,
  parameter bit SYNC_POL = 1'b0,
  parameter int CHK_LOG2 = 5,
  parameter int ADDR_W   = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_mode,
  input  logic [3*COLOR_W-1:0]   i_vga_data,
  output logic [ADDR_W-1:0]      o_h_addr,
  output logic [ADDR_W-1:0]      o_v_addr,
  output logic                   o_pix_en,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_valid,
  output logic [COLOR_W-1:0]     o_vga_r,
  output logic [COLOR_W-1:0]     o_vga_g,
  output logic [COLOR_W-1:0]     o_vga_b,
  output logic                   o_frame_start,
  output logic [15:0]            o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  // One extra bit so a zero back porch cannot overflow the sync-end constant
  localparam logic [HW:0]   H_ACT_END  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   H_SYNC_ON  = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   H_SYNC_OFF = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT_END  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   V_SYNC_ON  = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   V_SYNC_OFF = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]          r_div;
  logic                   r_pix_en;
  logic [HW-1:0]          r_h_cnt;
  logic [VW-1:0]          r_v_cnt;
  logic [1:0]             r_mode;
  logic [BW-1:0]          r_bar_px;
  logic [3:0]             r_bar_idx;
  logic                   r_hsync;
  logic                   r_vsync;
  logic                   r_valid;
  logic [3*COLOR_W-1:0]   r_rgb;
  logic                   r_frame_start;
  logic [15:0]            r_frame_cnt;

  logic                   w_h_wrap;
  logic                   w_v_wrap;
  logic                   w_active;
  logic                   w_hs_act;
  logic                   w_vs_act;
  logic                   w_frame_first;
  logic [1:0]             w_mode;
  logic [ADDR_W-1:0]      w_xor;
  logic [2:0]             w_bar;
  logic [3*COLOR_W-1:0]   w_rgb;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_pix_en <= (r_div == DIV_LAST);
      r_div    <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
    end
  end

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_pix_en) begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + HW'(1);
      if (w_h_wrap) begin
        r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + VW'(1);
      end
    end
  end

  assign w_active = ({1'b0, r_h_cnt} < H_ACT_END) && ({1'b0, r_v_cnt} < V_ACT_END);
  assign w_hs_act = ({1'b0, r_h_cnt} >= H_SYNC_ON) && ({1'b0, r_h_cnt} < H_SYNC_OFF);
  assign w_vs_act = ({1'b0, r_v_cnt} >= V_SYNC_ON) && ({1'b0, r_v_cnt} < V_SYNC_OFF);
  assign o_h_addr = w_active ? ADDR_W'(r_h_cnt) : '0;
  assign o_v_addr = w_active ? ADDR_W'(r_v_cnt) : '0;

  // The frame's first pixel already uses the newly sampled mode.
  assign w_frame_first = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_mode        = w_frame_first ? i_mode : r_mode;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= 2'b00;
    end else if (r_pix_en && w_frame_first) begin
      r_mode <= i_mode;
    end
  end

  // Bar index 8 means past the last full bar: remainder pixels are black.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bar_px  <= '0;
      r_bar_idx <= '0;
    end else if (r_pix_en) begin
      if (w_h_wrap) begin
        r_bar_px  <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_px == BAR_LAST) begin
        r_bar_px <= '0;
        if (!r_bar_idx[3]) begin
          r_bar_idx <= r_bar_idx + 4'd1;
        end
      end else begin
        r_bar_px <= r_bar_px + BW'(1);
      end
    end
  end

  assign w_bar = {~r_bar_idx[1], ~r_bar_idx[2], ~r_bar_idx[0]} & {3{~r_bar_idx[3]}};
  assign w_xor = o_h_addr ^ o_v_addr;

  always_comb begin
    w_rgb = '0;
    case (w_mode)
      2'b01:   w_rgb = {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}};
      2'b10:   w_rgb = w_xor[CHK_LOG2] ? '0 : '1;
      default: w_rgb = i_vga_data;
    endcase
    if (!w_active) begin
      w_rgb = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_valid       <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else if (r_pix_en) begin
      r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_valid       <= w_active;
      r_rgb         <= w_rgb;
      r_frame_start <= w_frame_first;
      if (w_h_wrap && w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign o_pix_en      = r_pix_en;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_valid       = r_valid;
  assign o_vga_r       = r_rgb[3*COLOR_W-1:2*COLOR_W];
  assign o_vga_g       = r_rgb[2*COLOR_W-1:COLOR_W];
  assign o_vga_b       = r_rgb[COLOR_W-1:0];
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Randomised bench for vga_ctrl_param: an arithmetic pixel-position model is
// compared against every DUT output on every falling clock edge.
module tb_vga_ctrl_param;

  localparam int HA = 16, HFP = 2, HS = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int D = 3, CHK = 1, AW = 6;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    i_mode = 2'b00;
  logic [7:0]    salt = 8'h00;
  logic [23:0]   i_vga_data;
  logic [AW-1:0] o_h_addr, o_v_addr;
  logic          o_pix_en, o_hsync, o_vsync, o_valid, o_frame_start;
  logic [7:0]    o_vga_r, o_vga_g, o_vga_b;
  logic [15:0]   o_frame_cnt;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_ctrl_param #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(D), .COLOR_W(8), .SYNC_POL(1'b0), .CHK_LOG2(CHK), .ADDR_W(AW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(i_mode), .i_vga_data(i_vga_data),
    .o_h_addr(o_h_addr), .o_v_addr(o_v_addr), .o_pix_en(o_pix_en),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_valid(o_valid),
    .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b),
    .o_frame_start(o_frame_start), .o_frame_cnt(o_frame_cnt)
  );

  function automatic logic [23:0] fb(int h, int v, logic [7:0] s);
    return {8'(h * 5) + s, 8'(v * 9 + 1), s ^ 8'(h + v)};
  endfunction

  assign i_vga_data = fb(int'(o_h_addr), int'(o_v_addr), salt);

  function automatic logic [23:0] colour(logic [1:0] m, int h, int v, logic [7:0] s);
    int b;
    case (m)
      2'b01: begin
        b = h / (HA / 8);
        case (b)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'b10: return (((h ^ v) >> CHK) & 1) != 0 ? 24'h000000 : 24'hFFFFFF;
      default: return fb(h, v, s);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = clock edges since reset release; the pixel position follows by division.
  int k;
  int cur_p, cur_h, cur_v;
  logic cur_act, cur_first;
  logic [1:0]  m_mode;
  logic        e_hs, e_vs, e_val, e_fs;
  logic [23:0] e_rgb;
  logic [15:0] e_fc;

  assign cur_p     = (k >= 1) ? (k - 1) / D : 0;
  assign cur_h     = cur_p % HT;
  assign cur_v     = (cur_p / HT) % VT;
  assign cur_act   = (cur_h < HA) && (cur_v < VA);
  assign cur_first = (cur_h == 0) && (cur_v == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; m_mode <= 2'b00;
      e_hs <= 1'b1; e_vs <= 1'b1; e_val <= 1'b0; e_rgb <= 24'h0; e_fs <= 1'b0; e_fc <= 16'h0;
    end else begin
      k <= k + 1;
      if (k >= 1 && k % D == 0) begin
        if (cur_first) m_mode <= i_mode;
        e_hs  <= !(cur_h >= HA + HFP && cur_h < HA + HFP + HS);
        e_vs  <= !(cur_v >= VA + VFP && cur_v < VA + VFP + VS);
        e_val <= cur_act;
        e_rgb <= cur_act ? colour(cur_first ? i_mode : m_mode, cur_h, cur_v, salt) : 24'h0;
        e_fs  <= cur_first;
        e_fc  <= 16'((cur_p + 1) / FT);
      end
    end
  end

  always @(negedge clk) begin
    check("pix_en", 32'(o_pix_en), 32'(k >= 1 && k % D == 0));
    check("h_addr", 32'(o_h_addr), cur_act ? 32'(cur_h) : 32'd0);
    check("v_addr", 32'(o_v_addr), cur_act ? 32'(cur_v) : 32'd0);
    check("hsync", 32'(o_hsync), 32'(e_hs));
    check("vsync", 32'(o_vsync), 32'(e_vs));
    check("valid", 32'(o_valid), 32'(e_val));
    check("rgb", 32'({o_vga_r, o_vga_g, o_vga_b}), 32'(e_rgb));
    check("frame_start", 32'(o_frame_start), 32'(e_fs));
    check("frame_cnt", 32'(o_frame_cnt), 32'(e_fc));
  end

  task automatic step(bit rnd_mode);
    @(negedge clk);
    salt = 8'($urandom);
    if (rnd_mode && $urandom_range(0, 40) == 0) i_mode = 2'($urandom);
  endtask

  task automatic wait_frame_start(output bit ok);
    logic prev;
    ok = 1'b0;
    prev = o_frame_start;
    for (int t = 0; t < 1000 && !ok; t++) begin
      step(1'b0);
      if (o_frame_start && !prev) ok = 1'b1;
      prev = o_frame_start;
    end
  endtask

  task automatic measure();
    int first, second, nv, nh, nvs;
    logic prev;
    first = -1; second = -1; nv = 0; nh = 0; nvs = 0;
    prev = o_frame_start;
    for (int t = 0; t < 2000 && second < 0; t++) begin
      step(1'b0);
      if (o_frame_start && !prev) begin
        if (first < 0) first = t;
        else second = t;
      end
      if (first >= 0 && second < 0) begin
        nv += int'(o_valid);
        nh += int'(!o_hsync);
        nvs += int'(!o_vsync);
      end
      prev = o_frame_start;
    end
    check("frame_period", 32'(second - first), 32'(462));
    check("valid_cycles", 32'(nv), 32'(192));
    check("hsync_low_cycles", 32'(nh), 32'(42));
    check("vsync_low_cycles", 32'(nvs), 32'(66));
  endtask

  initial begin
    bit ok;
    logic [15:0] fc0;

    check("pin_bar_white", 32'(colour(2'b01, 0, 0, 8'h0)), 32'h00FFFFFF);
    check("pin_bar_yellow", 32'(colour(2'b01, 3, 1, 8'h0)), 32'h00FFFF00);
    check("pin_bar_black", 32'(colour(2'b01, 15, 0, 8'h0)), 32'h00000000);
    check("pin_chk_00", 32'(colour(2'b10, 0, 0, 8'h0)), 32'h00FFFFFF);
    check("pin_chk_20", 32'(colour(2'b10, 2, 0, 8'h0)), 32'h00000000);
    check("pin_chk_22", 32'(colour(2'b10, 2, 2, 8'h0)), 32'h00FFFFFF);

    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    repeat (2 * 462) step(1'b0);
    measure();

    i_mode = 2'b01; repeat (500) step(1'b0);
    i_mode = 2'b10; repeat (500) step(1'b0);
    i_mode = 2'b11; repeat (600) step(1'b1);

    i_mode = 2'b00;
    wait_frame_start(ok);
    check("wait_start_a", 32'(ok), 32'd1);
    repeat (60) step(1'b0);
    i_mode = 2'b11;
    fc0 = o_frame_cnt;
    wait_frame_start(ok);
    check("wait_start_b", 32'(ok), 32'd1);
    check("frame_cnt_step", 32'(o_frame_cnt), 32'(fc0 + 16'd1));

    i_mode = 2'b10;
    repeat (300) step(1'b0);
    ok = 1'b0;
    for (int t = 0; t < 1000 && !ok; t++) begin
      step(1'b0);
      if (o_valid && o_vga_r != 8'h00 && o_frame_cnt != 16'h0) ok = 1'b1;
    end
    check("find_lit_pixel", 32'(ok), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_rgb", 32'({o_vga_r, o_vga_g, o_vga_b}), 32'd0);
    check("arst_hsync", 32'(o_hsync), 32'd1);
    check("arst_vsync", 32'(o_vsync), 32'd1);
    check("arst_frame_cnt", 32'(o_frame_cnt), 32'd0);
    check("arst_pix_en", 32'(o_pix_en), 32'd0);
    check("arst_addr", 32'({o_h_addr, o_v_addr}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (700) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
